// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of the two requester ports
// and the shared single-port RAM port.
interface mem_port_arbiter_if #(
  parameter int MEM_WIDTH  = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  p0_rden;
  logic                  p0_wren;
  logic [ADDR_WIDTH-1:0] p0_address;
  logic [MEM_WIDTH-1:0]  p0_wdata;
  logic                  p0_ack;
  logic [MEM_WIDTH-1:0]  p0_rdata;

  logic                  p1_rden;
  logic                  p1_wren;
  logic [ADDR_WIDTH-1:0] p1_address;
  logic [MEM_WIDTH-1:0]  p1_wdata;
  logic                  p1_ack;
  logic [MEM_WIDTH-1:0]  p1_rdata;

  logic                  mrden;
  logic                  mwren;
  logic [ADDR_WIDTH-1:0] maddress;
  logic [MEM_WIDTH-1:0]  mdout;
  logic [MEM_WIDTH-1:0]  mq;
  logic                  busy;

  modport slave (
    input  p0_rden, p0_wren, p0_address, p0_wdata,
    output p0_ack, p0_rdata,
    input  p1_rden, p1_wren, p1_address, p1_wdata,
    output p1_ack, p1_rdata,
    output mrden, mwren, maddress, mdout, busy,
    input  mq
  );

  modport master (
    output p0_rden, p0_wren, p0_address, p0_wdata,
    input  p0_ack, p0_rdata,
    output p1_rden, p1_wren, p1_address, p1_wdata,
    input  p1_ack, p1_rdata,
    input  mrden, mwren, maddress, mdout, busy,
    output mq
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one
// single-port RAM between two cache requesters.
module mem_port_arbiter #(
  parameter int MEM_WIDTH  = 32,
  parameter int MEM_DEPTH  = 65536,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state_q;
  logic                  owner_q;
  logic                  last_q;
  logic                  mrden_q;
  logic                  mwren_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [MEM_WIDTH-1:0]  wdata_q;

  logic                  req0;
  logic                  req1;
  logic                  gnt1_d;
  logic                  wr_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [MEM_WIDTH-1:0]  wdata_d;

  // Pick the winner and mux its request; write beats read.
  always_comb begin
    req0    = bus.p0_rden | bus.p0_wren;
    req1    = bus.p1_rden | bus.p1_wren;
    gnt1_d  = req1 & (~req0 | ~last_q);
    wr_d    = gnt1_d ? bus.p1_wren : bus.p0_wren;
    addr_d  = gnt1_d ? bus.p1_address : bus.p0_address;
    wdata_d = gnt1_d ? bus.p1_wdata : bus.p0_wdata;
  end

  // Sequencer: capture request, drive RAM one cycle, ack.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      mrden_q <= 1'b0;
      mwren_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            owner_q <= gnt1_d;
            mrden_q <= ~wr_d;
            mwren_q <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          mrden_q <= 1'b0;
          mwren_q <= 1'b0;
          state_q <= RESP;
        end
        RESP: begin
          last_q  <= owner_q;
          state_q <= IDLE;
        end
        default: begin
          mrden_q <= 1'b0;
          mwren_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mrden    = mrden_q;
  assign bus.mwren    = mwren_q;
  assign bus.maddress = addr_q;
  assign bus.mdout    = wdata_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.p0_ack   = (state_q == RESP) & ~owner_q;
  assign bus.p1_ack   = (state_q == RESP) & owner_q;
  assign bus.p0_rdata = bus.mq;
  assign bus.p1_rdata = bus.mq;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of the two-port
// arbiter against a registered-read RAM model.
module tb_mem_port_arbiter;

  localparam int MW = 32;
  localparam int AW = 16;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [MW-1:0] ram [0:65535];

  mem_port_arbiter_if #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW)) bus ();

  mem_port_arbiter #(
    .MEM_WIDTH(MW),
    .MEM_DEPTH(65536),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mwren) ram[bus.maddress] <= bus.mdout;
    if (bus.mrden) bus.mq <= ram[bus.maddress];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p0(input logic rd, input logic wr,
                        input logic [AW-1:0] a,
                        input logic [MW-1:0] d);
    bus.p0_rden = rd;
    bus.p0_wren = wr;
    bus.p0_address = a;
    bus.p0_wdata = d;
  endtask

  task automatic set_p1(input logic rd, input logic wr,
                        input logic [AW-1:0] a,
                        input logic [MW-1:0] d);
    bus.p1_rden = rd;
    bus.p1_wren = wr;
    bus.p1_address = a;
    bus.p1_wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_p0(1'b1, 1'b0, 16'h0010, '0);
    set_p1(1'b1, 1'b0, 16'h0020, '0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({bus.mrden, bus.mwren, bus.p0_ack,
           bus.p1_ack, bus.busy} !== 5'b0) begin
        errors++;
        $display("FAIL reset_ctl: got %b want 00000",
          {bus.mrden, bus.mwren, bus.p0_ack,
           bus.p1_ack, bus.busy});
      end
      checks++;
      if (bus.maddress !== 16'h0 || bus.mdout !== 32'h0) begin
        errors++;
        $display("FAIL reset_bus: addr %h dout %h want 0",
          bus.maddress, bus.mdout);
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.mrden !== 1'b1 || bus.maddress !== 16'h0010) begin
      errors++;
      $display("FAIL reset_tie_issue: rden %b addr %h want 1 0010",
        bus.mrden, bus.maddress);
    end
    tick();
    checks++;
    if (bus.p0_ack !== 1'b1 || bus.p1_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_tie_ack: p0 %b p1 %b want 1 0",
        bus.p0_ack, bus.p1_ack);
    end
    checks++;
    if (bus.p0_rdata !== 32'h1111_1111) begin
      errors++;
      $display("FAIL reset_tie_data: got %h want 11111111",
        bus.p0_rdata);
    end
    set_p0(1'b0, 1'b0, '0, '0);
    set_p1(1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_single_read();
    set_p0(1'b1, 1'b0, 16'h0400, '0);
    tick();
    checks++;
    if (bus.mrden !== 1'b1 || bus.mwren !== 1'b0 ||
        bus.maddress !== 16'h0400 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL rd_issue: rd %b wr %b addr %h busy %b want 1 0 0400 1",
        bus.mrden, bus.mwren, bus.maddress, bus.busy);
    end
    tick();
    checks++;
    if (bus.mrden !== 1'b0 || bus.p0_ack !== 1'b1 ||
        bus.p1_ack !== 1'b0) begin
      errors++;
      $display("FAIL rd_resp: rd %b p0 %b p1 %b want 0 1 0",
        bus.mrden, bus.p0_ack, bus.p1_ack);
    end
    checks++;
    if (bus.p0_rdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL rd_data: got %h want cafef00d", bus.p0_rdata);
    end
    set_p0(1'b0, 1'b0, '0, '0);
    tick();
    checks++;
    if (bus.p0_ack !== 1'b0 || bus.busy !== 1'b0 ||
        bus.mrden !== 1'b0) begin
      errors++;
      $display("FAIL rd_idle: ack %b busy %b rd %b want 0 0 0",
        bus.p0_ack, bus.busy, bus.mrden);
    end
  endtask

  task automatic test_write_read();
    set_p1(1'b0, 1'b1, 16'h1234, 32'hBBBB_BBBB);
    tick();
    checks++;
    if (bus.mwren !== 1'b1 || bus.mrden !== 1'b0 ||
        bus.mdout !== 32'hBBBB_BBBB ||
        bus.maddress !== 16'h1234) begin
      errors++;
      $display("FAIL wr_issue: wr %b rd %b dout %h addr %h",
        bus.mwren, bus.mrden, bus.mdout, bus.maddress);
    end
    tick();
    checks++;
    if (bus.p1_ack !== 1'b1 || bus.p0_ack !== 1'b0 ||
        bus.mwren !== 1'b0) begin
      errors++;
      $display("FAIL wr_resp: p1 %b p0 %b wr %b want 1 0 0",
        bus.p1_ack, bus.p0_ack, bus.mwren);
    end
    set_p1(1'b0, 1'b0, '0, '0);
    tick();
    set_p1(1'b1, 1'b0, 16'h1234, '0);
    tick();
    tick();
    checks++;
    if (bus.p1_ack !== 1'b1 || bus.p1_rdata !== 32'hBBBB_BBBB) begin
      errors++;
      $display("FAIL wr_readback: ack %b data %h want 1 bbbbbbbb",
        bus.p1_ack, bus.p1_rdata);
    end
    set_p1(1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_tie();
    logic          own;
    logic [AW-1:0] ea;
    logic [MW-1:0] ed;
    set_p0(1'b1, 1'b0, 16'h0010, '0);
    set_p1(1'b1, 1'b0, 16'h0020, '0);
    for (int i = 0; i < 4; i++) begin
      own = i[0];
      ea  = own ? 16'h0020 : 16'h0010;
      ed  = own ? 32'h2222_2222 : 32'h1111_1111;
      tick();
      checks++;
      if (bus.mrden !== 1'b1 || bus.maddress !== ea) begin
        errors++;
        $display("FAIL tie_issue%0d: rd %b addr %h want 1 %h",
          i, bus.mrden, bus.maddress, ea);
      end
      tick();
      checks++;
      if (bus.p0_ack !== ~own || bus.p1_ack !== own) begin
        errors++;
        $display("FAIL tie_ack%0d: p0 %b p1 %b want %b %b",
          i, bus.p0_ack, bus.p1_ack, ~own, own);
      end
      checks++;
      if ((own ? bus.p1_rdata : bus.p0_rdata) !== ed) begin
        errors++;
        $display("FAIL tie_data%0d: got %h want %h", i,
          own ? bus.p1_rdata : bus.p0_rdata, ed);
      end
      if (own) set_p1(1'b0, 1'b0, '0, '0);
      else     set_p0(1'b0, 1'b0, '0, '0);
      tick();
      checks++;
      if (bus.p0_ack !== 1'b0 || bus.p1_ack !== 1'b0 ||
          bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL tie_idle%0d: p0 %b p1 %b busy %b want 0 0 0",
          i, bus.p0_ack, bus.p1_ack, bus.busy);
      end
      if (i < 3) begin
        if (own) set_p1(1'b1, 1'b0, 16'h0020, '0);
        else     set_p0(1'b1, 1'b0, 16'h0010, '0);
      end
    end
    set_p0(1'b0, 1'b0, '0, '0);
    set_p1(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_rdwr_both();
    set_p0(1'b1, 1'b1, 16'h0008, 32'h5555_AAAA);
    tick();
    checks++;
    if (bus.mwren !== 1'b1 || bus.mrden !== 1'b0 ||
        bus.mdout !== 32'h5555_AAAA) begin
      errors++;
      $display("FAIL rdwr_issue: wr %b rd %b dout %h want 1 0 5555aaaa",
        bus.mwren, bus.mrden, bus.mdout);
    end
    tick();
    set_p0(1'b0, 1'b0, '0, '0);
    tick();
    set_p0(1'b1, 1'b0, 16'h0008, '0);
    tick();
    tick();
    checks++;
    if (bus.p0_ack !== 1'b1 || bus.p0_rdata !== 32'h5555_AAAA) begin
      errors++;
      $display("FAIL rdwr_readback: ack %b data %h want 1 5555aaaa",
        bus.p0_ack, bus.p0_rdata);
    end
    set_p0(1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_reset_mid();
    set_p1(1'b1, 1'b0, 16'h0020, '0);
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.p1_ack !== 1'b0 || bus.busy !== 1'b0 ||
        bus.mrden !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_abandon: ack %b busy %b rd %b want 0 0 0",
        bus.p1_ack, bus.busy, bus.mrden);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.mrden !== 1'b1 || bus.maddress !== 16'h0020) begin
      errors++;
      $display("FAIL rstmid_issue: rd %b addr %h want 1 0020",
        bus.mrden, bus.maddress);
    end
    tick();
    checks++;
    if (bus.p1_ack !== 1'b1 || bus.p1_rdata !== 32'h2222_2222) begin
      errors++;
      $display("FAIL rstmid_resp: ack %b data %h want 1 22222222",
        bus.p1_ack, bus.p1_rdata);
    end
    set_p1(1'b0, 1'b0, '0, '0);
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    bus.mq = '0;
    set_p0(1'b0, 1'b0, '0, '0);
    set_p1(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 65536; i++) ram[i] = '0;
    ram[16'h0400] = 32'hCAFE_F00D;
    ram[16'h0010] = 32'h1111_1111;
    ram[16'h0020] = 32'h2222_2222;
    #1;
    test_reset();
    test_single_read();
    test_write_read();
    test_tie();
    test_rdwr_both();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
